// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks IDLE -> IF1 -> IF2 -> UPDATE per instruction,
// drives the memory read port from pc and captures the returned word into ir.
module fetch_unit #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF1,
        S_IF2,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              mem_rd_q, mem_rd_d;
    logic              ir_valid_q, ir_valid_d;
    logic              halted_q, halted_d;

    // Next-state, pc/ir updates, and state-decoded outputs registered off state_d
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
        halted_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d = pc_target;
                end
                if (halt) begin
                    state_d = S_HALT;
                end else if (fetch_req) begin
                    state_d = S_IF1;
                end
            end
            S_IF1: begin
                state_d = S_IF2;
            end
            S_IF2: begin
                ir_d    = mem_rdata;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                pc_d    = pc_load ? pc_target : ADDR_W'(pc_q + ADDR_W'(1));
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_rd_d   = (state_d == S_IF1) || (state_d == S_IF2);
        ir_valid_d = (state_d == S_UPDATE);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            mem_rd_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_rd_q   <= mem_rd_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch sequence.
module tb_fetch_unit;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              halt;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              halted;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int unsigned tests_run;
    int unsigned tests_failed;

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .halt      (halt),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .pc        (pc),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; halt = 1'b0; pc_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (pc !== 9'd0 || ir !== 16'd0 || ir_valid !== 1'b0 || mem_rd !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state got pc=%h ir=%h irv=%b rd=%b hlt=%b exp all zero",
                     pc, ir, ir_valid, mem_rd, halted);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        fetch_req = 1'b1;
        step();                                   // IF1
        fetch_req = 1'b0;
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 9'd0 || ir_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_if1 got rd=%b addr=%h irv=%b exp rd=1 addr=0 irv=0", mem_rd, mem_addr, ir_valid);
        end
        step();                                   // IF2
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 9'd0) begin
            tests_failed++;
            $display("FAIL single_if2 got rd=%b addr=%h exp rd=1 addr=0", mem_rd, mem_addr);
        end
        step();                                   // UPDATE, N+3
        tests_run++;
        if (ir_valid !== 1'b1 || ir !== 16'hD005 || mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_update got irv=%b ir=%h rd=%b exp irv=1 ir=d005 rd=0", ir_valid, ir, mem_rd);
        end
        step();                                   // IDLE
        tests_run++;
        if (pc !== 9'd1 || ir_valid !== 1'b0 || ir !== 16'hD005) begin
            tests_failed++;
            $display("FAIL single_after got pc=%h irv=%b ir=%h exp pc=1 irv=0 ir=d005", pc, ir_valid, ir);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        logic [ADDR_W-1:0] exp_pc;
        do_reset();
        fetch_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_v  = ((k % 4) == 3);
            exp_pc = ADDR_W'(k / 4);
            tests_run++;
            if (ir_valid !== exp_v || pc !== exp_pc || (exp_v && ir !== mem[k / 4])) begin
                tests_failed++;
                $display("FAIL b2b cyc %0d got irv=%b pc=%h ir=%h exp irv=%b pc=%h ir=%h",
                         k, ir_valid, pc, ir, exp_v, exp_pc, mem[k / 4]);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        pc_load = 1'b1; pc_target = 9'd5;
        step();
        pc_load = 1'b0;
        tests_run++;
        if (pc !== 9'd5) begin
            tests_failed++;
            $display("FAIL redir_idle_load got pc=%h exp 005", pc);
        end
        fetch_req = 1'b1;
        step();                                   // IF1
        fetch_req = 1'b0; pc_load = 1'b1; pc_target = 9'd100;
        step();                                   // IF2; load during IF1 ignored
        tests_run++;
        if (pc !== 9'd5 || mem_addr !== 9'd5) begin
            tests_failed++;
            $display("FAIL redir_ignored got pc=%h addr=%h exp 005", pc, mem_addr);
        end
        step();                                   // UPDATE; load during IF2 ignored
        pc_target = 9'd40;
        tests_run++;
        if (pc !== 9'd5 || ir !== mem[5] || ir_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_update got pc=%h ir=%h irv=%b exp pc=005 ir=%h irv=1", pc, ir, ir_valid, mem[5]);
        end
        step();                                   // IDLE
        pc_load = 1'b0;
        tests_run++;
        if (pc !== 9'd40) begin
            tests_failed++;
            $display("FAIL redir_pc got %h exp 028", pc);
        end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        tests_run++;
        if (mem_addr !== 9'd40 || mem_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_next_addr got addr=%h rd=%b exp 028 rd=1", mem_addr, mem_rd);
        end
        step(); step();
        tests_run++;
        if (ir !== mem[40]) begin
            tests_failed++;
            $display("FAIL redir_next_ir got %h exp %h", ir, mem[40]);
        end
        step();
        tests_run++;
        if (pc !== 9'd41) begin
            tests_failed++;
            $display("FAIL redir_next_pc got %h exp 029", pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pc_load = 1'b1; pc_target = 9'd511; fetch_req = 1'b1;
        step();                                   // IF1 at 511
        pc_load = 1'b0; fetch_req = 1'b0;
        tests_run++;
        if (mem_addr !== 9'd511 || mem_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_addr got addr=%h rd=%b exp 1ff rd=1", mem_addr, mem_rd);
        end
        step(); step();
        tests_run++;
        if (ir !== mem[511] || ir_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_ir got ir=%h irv=%b exp %h irv=1", ir, ir_valid, mem[511]);
        end
        step();
        tests_run++;
        if (pc !== 9'd0) begin
            tests_failed++;
            $display("FAIL wrap_pc got %h exp 000", pc);
        end
    endtask

    task automatic test_halt();
        logic [ADDR_W-1:0] held_pc;
        logic [DATA_W-1:0] held_ir;
        do_reset();
        pc_load = 1'b1; pc_target = 9'd3;
        step();
        pc_load = 1'b0;
        held_pc = pc;
        held_ir = ir;
        halt = 1'b1; fetch_req = 1'b1;
        step();
        halt = 1'b0;
        tests_run++;
        if (halted !== 1'b1 || mem_rd !== 1'b0 || pc !== 9'd3) begin
            tests_failed++;
            $display("FAIL halt_enter got hlt=%b rd=%b pc=%h exp hlt=1 rd=0 pc=003", halted, mem_rd, pc);
        end
        pc_load = 1'b1; pc_target = 9'd77;
        for (int k = 0; k < 6; k++) begin
            step();
            tests_run++;
            if (halted !== 1'b1 || mem_rd !== 1'b0 || ir_valid !== 1'b0 || pc !== held_pc || ir !== held_ir) begin
                tests_failed++;
                $display("FAIL halt_hold cyc %0d got hlt=%b rd=%b irv=%b pc=%h ir=%h exp 1 0 0 %h %h",
                         k, halted, mem_rd, ir_valid, pc, ir, held_pc, held_ir);
            end
        end
        reset = 1'b1;
        step();
        idle_inputs();
        tests_run++;
        if (halted !== 1'b0 || pc !== 9'd0) begin
            tests_failed++;
            $display("FAIL halt_exit got hlt=%b pc=%h exp hlt=0 pc=000", halted, pc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        step(); step(); step();                   // ir now holds mem[0] (non-zero)
        fetch_req = 1'b1;
        step();                                   // IF1
        fetch_req = 1'b0;
        step();                                   // IF2
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (pc !== 9'd0 || ir !== 16'd0 || ir_valid !== 1'b0 || mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid got pc=%h ir=%h irv=%b rd=%b exp all zero", pc, ir, ir_valid, mem_rd);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_quiet cyc %0d got irv=%b rd=%b exp 0 0", k, ir_valid, mem_rd);
            end
        end
    endtask

    // Model: a fetch is a 3-cycle transaction started from idle; "age" is its progress.
    task automatic test_random();
        logic [ADDR_W-1:0] m_pc;
        logic [DATA_W-1:0] m_ir;
        logic              m_halted;
        int                age;
        do_reset();
        m_pc = '0; m_ir = '0; m_halted = 1'b0; age = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset     = ($urandom_range(0, 59) == 0);
            halt      = ($urandom_range(0, 39) == 0);
            fetch_req = ($urandom_range(0, 2) != 0);
            pc_load   = ($urandom_range(0, 3) == 0);
            pc_target = ADDR_W'($urandom_range(0, DEPTH - 1));

            if (reset) begin
                m_pc = '0; m_ir = '0; m_halted = 1'b0; age = 0;
            end else if (m_halted) begin
                age = 0;
            end else if (age == 0) begin
                if (pc_load) m_pc = pc_target;
                if (halt) m_halted = 1'b1;
                else if (fetch_req) age = 1;
            end else if (age == 1) begin
                age = 2;
            end else if (age == 2) begin
                m_ir = mem[m_pc];
                age  = 3;
            end else begin
                m_pc = pc_load ? pc_target : ADDR_W'((int'(m_pc) + 1) % DEPTH);
                age  = 0;
            end

            step();
            tests_run++;
            if (pc !== m_pc || mem_addr !== m_pc || ir !== m_ir) begin
                tests_failed++;
                $display("FAIL rand_data cyc %0d got pc=%h addr=%h ir=%h exp pc=%h ir=%h",
                         cyc, pc, mem_addr, ir, m_pc, m_ir);
            end
            tests_run++;
            if (mem_rd !== (age == 1 || age == 2) || ir_valid !== (age == 3) || halted !== m_halted) begin
                tests_failed++;
                $display("FAIL rand_ctrl cyc %0d got rd=%b irv=%b hlt=%b exp rd=%b irv=%b hlt=%b",
                         cyc, mem_rd, ir_valid, halted, (age == 1 || age == 2), (age == 3), m_halted);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'($urandom);
        mem[0] = 16'hD005;
        mem[1] = 16'h1111;
        mem[2] = 16'h2222;
        mem[3] = 16'h3333;
        idle_inputs();
        mem_rdata = '0;
        step();

        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
